uninverter_stream: RTL and testbench
====================================

// Module: uninverter_stream
//
// PURPOSE
//   Receive end of the 32-bit word-inversion path. Accepts inverted words on a
//   valid/ready stream and restores each one as ('hFFFFFFFF - word), i.e. the
//   bitwise complement at WIDTH bits. Restored words are buffered in a small
//   FIFO and presented on a valid/ready output stream.
//   Status outputs: fill level and a count of delivered words.
//
// PARAMETERS
//   WIDTH  32  data word width; the all-ones constant is {WIDTH{1'b1}}
//   DEPTH  4   FIFO entries; power of two, >= 2
//   CNT_W  16  width of the delivered-word counter
//
// PORTS
//   clk        in   1               single clock, all logic on rising edge
//   rst_n      in   1               synchronous reset, active low
//   in_valid   in   1               inverted word present on in_data
//   in_ready   out  1               block can accept a word this cycle
//   in_data    in   WIDTH           inverted word
//   out_valid  out  1               restored word present on out_data
//   out_ready  in   1               downstream accepts out_data this cycle
//   out_data   out  WIDTH           restored word (head of FIFO)
//   level      out  $clog2(DEPTH)+1 current FIFO occupancy, 0..DEPTH
//   word_cnt   out  CNT_W           number of output transfers since reset
//
// BEHAVIOUR
// - Push = in_valid & in_ready. Pop = out_valid & out_ready. Both are sampled
//   on the rising edge of clk.
// - Restore on push: the stored entry is {WIDTH{1'b1}} - in_data. This is the
//   same as ~in_data; there is no carry or borrow beyond WIDTH.
// - in_ready = rst_n_q & (level != DEPTH). It depends only on registered
//   state; it has no combinational path from out_ready.
// - out_valid = (level != 0). out_data is the head entry. It is registered
//   and has no combinational path from in_data.
// - Latency: a word pushed at edge N is valid at out_data after edge N. There
//   is no same-cycle bypass.
// - Simultaneous push and pop with 0 < level < DEPTH: level is unchanged and
//   order is preserved.
// - Full (level == DEPTH): in_ready = 0, so no push. A pop that cycle frees an
//   entry, and in_ready rises in the next cycle.
// - Empty: a pop is impossible because out_valid = 0.
// - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
// - word_cnt increments on each pop and wraps from 2^CNT_W-1 to 0.
// - Reset (rst_n sampled low at any edge, including mid-stream):
//   - level=0, word_cnt=0, out_valid=0, out_data=0, in_ready=0 while low.
//   - in_ready=1 on the first edge after rst_n is sampled high.
//   - In-flight FIFO contents are discarded.
// - While out_valid=1 and out_ready=0, out_data holds stable.
//
// CONFIGURATION
//   UNINVERT_CHECK_EN (macro defined):
//     - Extra ports:
//         in_ref   in   WIDTH  original (pre-inversion) word, qualified by push
//         err      out  1      sticky mismatch flag
//         err_cnt  out  CNT_W  number of mismatching pushes
//     - On each push, if the restored value != in_ref: err sets and err_cnt
//       increments, saturating at 2^CNT_W-1.
//     - Both clear only on reset.
//     - The mismatching word is still stored and delivered unchanged.
//   Macro undefined: these ports and their logic are absent; everything else
//   is identical.
//
// TESTING
// 1. Single word: push 32'hFFFF0000, out_ready=1 -> out_data=32'h0000FFFF,
//    out_valid one cycle after the push, word_cnt=1, level returns to 0.
// 2. Fill and backpressure: out_ready=0, push 5 words into DEPTH=4 ->
//    in_ready=0 after the 4th push, 5th held; level=4.
//    Then out_ready=1 -> words out in order, 5th accepted the cycle after the
//    first pop.
// 3. Simultaneous push and pop at level=2 for 10 cycles -> level stays 2,
//    word_cnt=10, no reordering.
// 4. Edge values: push 32'h00000000 then 32'hFFFFFFFF -> out 32'hFFFFFFFF then
//    32'h00000000.
// 5. Reset mid-stream: level=3, assert rst_n=0 for 1 edge -> level=0,
//    out_valid=0, out_data=0, word_cnt=0.
//    in_ready=0 during reset and 1 on the edge after release.
//    No stale words appear afterwards.
// 6. UNINVERT_CHECK_EN: push in_data=32'h0F0F0F0F with in_ref=32'hF0F0F0F0 ->
//    err=0.
//    Then push in_data=32'h00000001 with in_ref=32'h00000000 -> err=1,
//    err_cnt=1, word still delivered as 32'hFFFFFFFE.

Source files
------------

// File: rtl/uninverter_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uninverter_stream                                          |
// | Description : Receive end of the word-inversion path. Each accepted      |
// |               inverted word is restored as (all-ones - word), which is   |
// |               the bitwise complement. Restored words go into a small     |
// |               FIFO and leave on a valid/ready output stream.             |
// | Optional    : UNINVERT_CHECK_EN - adds in_ref/err/err_cnt, which compare |
// |               each restored word against the original reference word.    |
// | Ports       : clk, rst_n (sync, active low)                              |
// |               in_valid/in_ready/in_data    inverted input stream         |
// |               out_valid/out_ready/out_data restored output stream        |
// |               level     FIFO occupancy 0..DEPTH                          |
// |               word_cnt  output transfers since reset (wraps)             |
// |               in_ref/err/err_cnt           (UNINVERT_CHECK_EN only)      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uninverter_stream #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         word_cnt
`ifdef UNINVERT_CHECK_EN
  ,
  input  logic [WIDTH-1:0]         in_ref,
  output logic                     err,
  output logic [CNT_W-1:0]         err_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [WIDTH-1:0] c_ALL_ONES = {WIDTH{1'b1}};
  localparam logic [LVL_W-1:0] c_FULL     = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

  // Registered state
  logic                rst_n_q;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q,  level_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;

  logic                w_push;
  logic                w_pop;
  logic [WIDTH-1:0]    w_restored;

  // Handshake flags come only from registered state.
  assign in_ready   = rst_n_q & (level_q != c_FULL);
  assign out_valid  = (level_q != '0);
  assign w_push     = in_valid & in_ready;
  assign w_pop      = out_valid & out_ready;
  assign w_restored = c_ALL_ONES - in_data;

  assign out_data   = out_data_q;
  assign level      = level_q;
  assign word_cnt   = word_cnt_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    word_cnt_d = word_cnt_q;
    out_data_d = '0;

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end

    case ({w_push, w_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // out_data is a register holding the next head. If the next head is the
    // slot being written this cycle (push into empty, or push+pop at level
    // 1), the memory does not hold it yet, so take the restored word.
    if (level_d != '0) begin
      if (w_push && (rd_ptr_d == wr_ptr_q)) begin
        out_data_d = w_restored;
      end else begin
        out_data_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_n_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      word_cnt_q <= '0;
      out_data_q <= '0;
    end else begin
      rst_n_q    <= 1'b1;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      word_cnt_q <= word_cnt_d;
      out_data_q <= out_data_d;
    end
  end

  // Storage needs no reset: level_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      mem_q[wr_ptr_q] <= w_restored;
    end
  end

`ifdef UNINVERT_CHECK_EN
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (w_push && (w_restored != in_ref)) begin
      err_d = 1'b1;
      if (err_cnt_q != c_CNT_MAX) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uninverter_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uninverter_stream                                       |
// | Description : Directed self-checking bench for uninverter_stream with    |
// |               hand-computed expected values.                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uninverter_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  level;
  logic [15:0] word_cnt;
`ifdef UNINVERT_CHECK_EN
  logic [31:0] in_ref;
  logic        err;
  logic [15:0] err_cnt;
`endif

  int n_vec;
  int n_err;

  uninverter_stream #(
    .WIDTH (32),
    .DEPTH (4),
    .CNT_W (16)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .word_cnt  (word_cnt)
`ifdef UNINVERT_CHECK_EN
    ,
    .in_ref    (in_ref),
    .err       (err),
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] pat_in  [5];
  logic [31:0] pat_out [5];

  initial begin
    n_vec = 0;
    n_err = 0;
    pat_in[0] = 32'h12345678; pat_out[0] = 32'hEDCBA987;
    pat_in[1] = 32'hDEADBEEF; pat_out[1] = 32'h21524110;
    pat_in[2] = 32'hA5A5A5A5; pat_out[2] = 32'h5A5A5A5A;
    pat_in[3] = 32'h00000001; pat_out[3] = 32'hFFFFFFFE;
    pat_in[4] = 32'h80000000; pat_out[4] = 32'h7FFFFFFF;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef UNINVERT_CHECK_EN
    in_ref    = '0;
`endif
    step();
    step();
    chk("rst_level",     64'(level),     64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_word_cnt",  64'(word_cnt),  64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    rst_n = 1'b1;
    step();
    chk("rel_in_ready",  64'(in_ready),  64'd1);

    // 1. single word
    in_valid  = 1'b1;
    in_data   = 32'hFFFF0000;
    out_ready = 1'b1;
`ifdef UNINVERT_CHECK_EN
    in_ref    = 32'h0000FFFF;
`endif
    step();
    in_valid = 1'b0;
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_out_data",  64'(out_data),  64'h0000FFFF);
    chk("t1_level",     64'(level),     64'd1);
    step();
    chk("t1_word_cnt",  64'(word_cnt),  64'd1);
    chk("t1_level0",    64'(level),     64'd0);
    chk("t1_empty",     64'(out_valid), 64'd0);

    // 2. fill and backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = pat_in[i];
`ifdef UNINVERT_CHECK_EN
      in_ref   = pat_out[i];
`endif
      step();
    end
    in_data = pat_in[4];
`ifdef UNINVERT_CHECK_EN
    in_ref  = pat_out[4];
`endif
    chk("t2_full_ready", 64'(in_ready), 64'd0);
    chk("t2_full_level", 64'(level),    64'd4);
    step();
    chk("t2_held_level", 64'(level),    64'd4);
    chk("t2_held_ready", 64'(in_ready), 64'd0);
    chk("t2_head0",      64'(out_data), 64'(pat_out[0]));
    out_ready = 1'b1;
    step();
    chk("t2_pop1_level", 64'(level),    64'd3);
    chk("t2_pop1_ready", 64'(in_ready), 64'd1);
    chk("t2_head1",      64'(out_data), 64'(pat_out[1]));
    step();
    in_valid = 1'b0;
    chk("t2_pushpop_lvl", 64'(level),   64'd3);
    for (int i = 2; i < 5; i++) begin
      chk("t2_order", 64'(out_data), 64'(pat_out[i]));
      step();
    end
    chk("t2_drained",  64'(level),    64'd0);
    chk("t2_word_cnt", 64'(word_cnt), 64'd6);

    // 3. simultaneous push/pop at level 2
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = 32'(i);
`ifdef UNINVERT_CHECK_EN
      in_ref  = 32'hFFFFFFFF - 32'(i);
`endif
      step();
    end
    chk("t3_pre_level", 64'(level), 64'd2);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = 32'(k + 2);
`ifdef UNINVERT_CHECK_EN
      in_ref  = 32'hFFFFFFFF - 32'(k + 2);
`endif
      chk("t3_head", 64'(out_data), 64'(32'hFFFFFFFF - 32'(k)));
      step();
      chk("t3_level", 64'(level), 64'd2);
    end
    chk("t3_word_cnt", 64'(word_cnt), 64'd16);
    in_valid = 1'b0;
    chk("t3_tail10", 64'(out_data), 64'hFFFFFFF5);
    step();
    chk("t3_tail11", 64'(out_data), 64'hFFFFFFF4);
    step();
    chk("t3_drained", 64'(level), 64'd0);

    // 4. edge values
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h00000000;
`ifdef UNINVERT_CHECK_EN
    in_ref    = 32'hFFFFFFFF;
`endif
    step();
    in_data   = 32'hFFFFFFFF;
`ifdef UNINVERT_CHECK_EN
    in_ref    = 32'h00000000;
`endif
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("t4_zero_in", 64'(out_data), 64'hFFFFFFFF);
    step();
    chk("t4_ones_in", 64'(out_data), 64'h00000000);
    chk("t4_valid",   64'(out_valid), 64'd1);
    step();
    chk("t4_word_cnt", 64'(word_cnt), 64'd20);

    // 5. reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = pat_in[i];
`ifdef UNINVERT_CHECK_EN
      in_ref  = pat_out[i];
`endif
      step();
    end
    chk("t5_pre_level", 64'(level), 64'd3);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    chk("t5_level",     64'(level),     64'd0);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_out_data",  64'(out_data),  64'd0);
    chk("t5_word_cnt",  64'(word_cnt),  64'd0);
    chk("t5_in_ready",  64'(in_ready),  64'd0);
    rst_n = 1'b1;
    step();
    chk("t5_rel_ready", 64'(in_ready),  64'd1);
    chk("t5_no_stale",  64'(out_valid), 64'd0);
    in_valid = 1'b1;
    in_data  = pat_in[4];
`ifdef UNINVERT_CHECK_EN
    in_ref   = pat_out[4];
`endif
    step();
    in_valid = 1'b0;
    chk("t5_fresh_level", 64'(level),    64'd1);
    chk("t5_fresh_data",  64'(out_data), 64'(pat_out[4]));
    out_ready = 1'b1;
    step();
    chk("t5_fresh_cnt",   64'(word_cnt), 64'd1);
    chk("t5_empty",       64'(out_valid), 64'd0);

`ifdef UNINVERT_CHECK_EN
    // 6. reference check
    chk("t6_err_clean", 64'(err), 64'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0F0F0F0F;
    in_ref    = 32'hF0F0F0F0;
    step();
    chk("t6_match_err", 64'(err),     64'd0);
    chk("t6_match_cnt", 64'(err_cnt), 64'd0);
    in_data   = 32'h00000001;
    in_ref    = 32'h00000000;
    step();
    in_valid  = 1'b0;
    chk("t6_err",     64'(err),     64'd1);
    chk("t6_err_cnt", 64'(err_cnt), 64'd1);
    out_ready = 1'b1;
    chk("t6_word0", 64'(out_data), 64'hF0F0F0F0);
    step();
    chk("t6_word1", 64'(out_data), 64'hFFFFFFFE);
    step();
    chk("t6_sticky", 64'(err), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
